// File: rtl/tx_fifo_rd_ctrl_pkg.sv
// tx_fifo_pkg: shared FSM state type and default geometry for the TX FIFO read controller.
// ERR exists only when TX_FIFO_STICKY_ERR_EN is defined.
package tx_fifo_pkg;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_LANES = 4;
`ifdef TX_FIFO_STICKY_ERR_EN
    typedef enum logic [1:0] {IDLE, STREAM, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif
endpackage

// File: rtl/tx_fifo_rd_ctrl_if.sv
// tx_fifo_rd_ctrl_if: control/status bundle between a TX FIFO reader and tx_fifo_rd_ctrl.
interface tx_fifo_rd_ctrl_if import tx_fifo_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = DEF_LANES
);
    logic                           clear;
    logic                           wr_word;
    logic                           rd_req;
    logic [$clog2(LANES):0]         rd_bytes;
    logic [$clog2(DEPTH)-1:0]       rd_idx;
    logic [$clog2(LANES)-1:0]       rd_lane;
    logic [$clog2(DEPTH*LANES):0]   byte_count;
    logic                           empty;
    logic                           full;
    logic                           rd_ack;
    logic                           underflow;
    logic                           overflow;
    modport master (
        output clear, wr_word, rd_req, rd_bytes,
        input  rd_idx, rd_lane, byte_count, empty, full, rd_ack, underflow, overflow
    );
    modport slave (
        input  clear, wr_word, rd_req, rd_bytes,
        output rd_idx, rd_lane, byte_count, empty, full, rd_ack, underflow, overflow
    );
endinterface

// File: rtl/tx_fifo_rd_ctrl_flex_counter.sv
// flex_counter: wrapping up-counter with sync clear, rolls from ROLL back to 0.
module flex_counter #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] ROLL  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_en)
            r_count <= (r_count == ROLL) ? '0 : r_count + 1'b1;
    assign o_count = r_count;
endmodule

// File: rtl/tx_fifo_rd_ctrl.sv
// tx_fifo_rd_ctrl: byte-granular read pointer/occupancy tracker for a word-written TX FIFO.
// Define TX_FIFO_STICKY_ERR_EN for a sticky ERR state on underflow; default is per-request pulses.
module tx_fifo_rd_ctrl import tx_fifo_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = DEF_LANES
) (
    input  logic              clk,
    input  logic              rst,
    tx_fifo_rd_ctrl_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(LANES);
    localparam int BW = $clog2(DEPTH*LANES) + 1;
    localparam int WW = IW + 1;

    state_t          r_state, w_state_n;
    logic [IW-1:0]   w_idx;
    logic [LW-1:0]   r_lane, w_lane_n;
    logic [LW:0]     w_lane_sum;
    logic [BW-1:0]   r_bytes, w_bytes_n, w_req;
    logic [WW-1:0]   r_words, w_words_n;
    logic            r_empty, r_full, r_ack, r_unf, r_ovf;
    logic            w_in_err, w_len_ok, w_acc, w_rej, w_wrap, w_wr_ok, w_unf_n;

`ifdef TX_FIFO_STICKY_ERR_EN
    assign w_in_err = (r_state == ERR);
`else
    assign w_in_err = 1'b0;
`endif

    // Acceptance is judged on the pre-write byte count.
    assign w_req      = BW'(bus.rd_bytes);
    assign w_len_ok   = (bus.rd_bytes != '0) && (bus.rd_bytes <= (LW+1)'(LANES));
    assign w_acc      = bus.rd_req && w_len_ok && (w_req <= r_bytes) && !w_in_err;
    assign w_rej      = bus.rd_req && !w_acc;
    assign w_lane_sum = {1'b0, r_lane} + bus.rd_bytes;
    assign w_wrap     = w_acc && (w_lane_sum >= (LW+1)'(LANES));
    // A full FIFO still takes a write when the same-cycle read retires the head word.
    assign w_wr_ok    = bus.wr_word && (!r_full || w_wrap);

    always_comb begin
        w_bytes_n = r_bytes - (w_acc ? w_req : '0) + (w_wr_ok ? BW'(LANES) : '0);
        w_words_n = r_words - WW'(w_wrap) + WW'(w_wr_ok);
        w_lane_n  = w_acc ? w_lane_sum[LW-1:0] : r_lane;
        w_state_n = (r_state == IDLE) ? (w_wr_ok ? STREAM : IDLE)
                                      : ((w_bytes_n == '0) ? IDLE : STREAM);
`ifdef TX_FIFO_STICKY_ERR_EN
        if (w_in_err || w_rej)
            w_state_n = ERR;
        w_unf_n   = r_unf || w_rej;
`else
        w_unf_n   = w_rej;
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_state <= IDLE;
        else if (bus.clear)
            r_state <= IDLE;
        else
            r_state <= w_state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_lane  <= '0;
            r_bytes <= '0;
            r_words <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ack   <= 1'b0;
            r_unf   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.clear) begin
            r_lane  <= '0;
            r_bytes <= '0;
            r_words <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ack   <= 1'b0;
            r_unf   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_lane  <= w_lane_n;
            r_bytes <= w_bytes_n;
            r_words <= w_words_n;
            r_empty <= (w_bytes_n == '0);
            r_full  <= (w_words_n == WW'(DEPTH));
            r_ack   <= w_acc;
            r_unf   <= w_unf_n;
            r_ovf   <= bus.wr_word && !w_wr_ok;
        end

    flex_counter #(.WIDTH(IW), .ROLL(IW'(DEPTH-1))) u_idx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.clear),
        .i_en    (w_wrap),
        .o_count (w_idx)
    );

    assign bus.rd_idx     = w_idx;
    assign bus.rd_lane    = r_lane;
    assign bus.byte_count = r_bytes;
    assign bus.empty      = r_empty;
    assign bus.full       = r_full;
    assign bus.rd_ack     = r_ack;
    assign bus.underflow  = r_unf;
    assign bus.overflow   = r_ovf;
endmodule
